// File: rtl/reg_file_sh_pkg.sv
// Shared constants and encodings for the ARM datapath register file and its read-port mux.
package reg_file_sh_pkg;

    localparam logic [3:0] REG_PC    = 4'd15;
    localparam int         NREG_DEF  = 15;
    localparam int         WIDTH_DEF = 32;
    localparam int         SHAMT_W   = 5;

    typedef enum logic {
        SHSRC_IMM = 1'b0,
        SHSRC_REG = 1'b1
    } shsrc_e;

endpackage

// File: rtl/reg_file_rd_mux.sv
// One combinational read port: R15 override first, then same-cycle write bypass, then stored value.
module reg_file_rd_mux
    import reg_file_sh_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int BYPASS = 1
) (
    input  logic [NREG-1:0][WIDTH-1:0] i_regs,
    input  logic [3:0]                 i_addr,
    input  logic [WIDTH-1:0]           i_r15,
    input  logic                       i_we,
    input  logic [3:0]                 i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata
);

    localparam logic [3:0] LAST_REG = 4'(NREG - 1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_rdata = '0;
        if (i_addr == REG_PC) begin
            o_rdata = i_r15;
        end else if ((BYPASS != 0) && i_we && (i_waddr == i_addr)) begin
            o_rdata = i_wdata;
        end else if (i_addr <= LAST_REG) begin
            o_rdata = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/reg_file_sh.sv
// ARM register file (R0..R14 in flops, R15 = PC+8) with three read ports and shift-amount selection.
module reg_file_sh
    import reg_file_sh_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int BYPASS = 1
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [3:0]         A1,
    input  logic [3:0]         A2,
    input  logic [3:0]         A4,
    input  logic [3:0]         A3,
    input  logic               WE3,
    input  logic [WIDTH-1:0]   WD3,
    input  logic [WIDTH-1:0]   R15,
    input  logic               ShamtSrc,
    input  logic [SHAMT_W-1:0] ImmShamt,
    output logic [WIDTH-1:0]   RD1,
    output logic [WIDTH-1:0]   RD2,
    output logic [WIDTH-1:0]   RD4,
    output logic [SHAMT_W-1:0] Shamt5,
    output logic               ShBig,
    output logic               ShZero
);

    localparam logic [3:0] LAST_REG = 4'(NREG - 1);

    logic [NREG-1:0][WIDTH-1:0] r_regs;
    logic                       w_wr_en;

    assign w_wr_en = WE3 && (A3 != REG_PC) && (A3 <= LAST_REG);

    // NOTE: the array is flops, not a RAM macro, so clearing it in reset is legal and required.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_regs <= '0;
        end else if (w_wr_en) begin
            r_regs[A3] <= WD3;
        end
    end

    reg_file_rd_mux #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(BYPASS)) u_rd1 (
        .i_regs (r_regs), .i_addr (A1), .i_r15 (R15),
        .i_we   (WE3),    .i_waddr(A3), .i_wdata(WD3), .o_rdata(RD1)
    );

    reg_file_rd_mux #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(BYPASS)) u_rd2 (
        .i_regs (r_regs), .i_addr (A2), .i_r15 (R15),
        .i_we   (WE3),    .i_waddr(A3), .i_wdata(WD3), .o_rdata(RD2)
    );

    reg_file_rd_mux #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(BYPASS)) u_rd4 (
        .i_regs (r_regs), .i_addr (A4), .i_r15 (R15),
        .i_we   (WE3),    .i_waddr(A3), .i_wdata(WD3), .o_rdata(RD4)
    );

    // Rs shifts look at the low byte only: bits 7:5 flag a shift of 32 or more.
    always_comb begin
        Shamt5 = ImmShamt;
        ShBig  = 1'b0;
        ShZero = (ImmShamt == '0);
        if (ShamtSrc == SHSRC_REG) begin
            Shamt5 = RD4[SHAMT_W-1:0];
            ShBig  = |RD4[7:5];
            ShZero = (RD4[7:0] == 8'd0);
        end
    end

endmodule
